// File: rtl/axi_burst_responder.sv
// AXI subordinate model: fixed-length AR/AW/W bursts served from a small line memory.
// Read and write channels run as independent FSMs, one outstanding transaction each.
module axi_burst_responder #(
    parameter int unsigned AXI_DATAWIDTH = 64,
    parameter int unsigned AXI_ADDRWIDTH = 32,
    parameter int unsigned AXI_IDWIDTH   = 4,
    parameter int unsigned AXI_USERWIDTH = 1,
    parameter int unsigned BURST_LENGTH  = 8,
    parameter int unsigned MEMLINES      = 16,
    parameter int unsigned READ_LATENCY  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDWIDTH-1:0]   ar_id,
    input  logic [AXI_USERWIDTH-1:0] ar_user,
    input  logic [AXI_ADDRWIDTH-1:0] ar_addr,
    input  logic                     ar_valid,
    output logic                     ar_ready,
    input  logic [AXI_IDWIDTH-1:0]   aw_id,
    input  logic [AXI_USERWIDTH-1:0] aw_user,
    input  logic [AXI_ADDRWIDTH-1:0] aw_addr,
    input  logic                     aw_valid,
    output logic                     aw_ready,
    input  logic [AXI_DATAWIDTH-1:0] w_data,
    input  logic [AXI_DATAWIDTH/8-1:0] w_strb,
    input  logic                     w_last,
    input  logic                     w_valid,
    output logic                     w_ready,
    output logic [AXI_IDWIDTH-1:0]   r_id,
    output logic [AXI_USERWIDTH-1:0] r_user,
    output logic [AXI_DATAWIDTH-1:0] r_data,
    output logic                     r_last,
    output logic [1:0]               r_resp,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [AXI_IDWIDTH-1:0]   b_id,
    output logic [AXI_USERWIDTH-1:0] b_user,
    output logic [1:0]               b_resp,
    output logic                     b_valid,
    input  logic                     b_ready
);

    localparam int unsigned STRB_W = AXI_DATAWIDTH / 8;
    localparam int unsigned BEAT_W = $clog2(BURST_LENGTH);
    localparam int unsigned LINE_W = $clog2(MEMLINES);
    localparam int unsigned OFF    = $clog2(BURST_LENGTH * STRB_W);
    localparam int unsigned WORDS  = MEMLINES * BURST_LENGTH;
    localparam int unsigned LAT_W  = $clog2(READ_LATENCY) + 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [AXI_DATAWIDTH-1:0] mem [WORDS];

    // Only the line-index bits of the address select storage; the rest are ignored.
    logic unused_addr;
    assign unused_addr = ^{ar_addr[AXI_ADDRWIDTH-1:OFF+LINE_W], ar_addr[OFF-1:0],
                           aw_addr[AXI_ADDRWIDTH-1:OFF+LINE_W], aw_addr[OFF-1:0]};

    assign r_resp = 2'b00;

    // ---------------- write path ----------------
    wstate_t                  w_state, w_state_nx;
    logic [LINE_W-1:0]        w_line, w_line_nx;
    logic [BEAT_W-1:0]        w_beat, w_beat_nx;
    logic                     w_err, w_err_nx, w_err_now;
    logic                     w_fire, w_last_beat;
    logic                     aw_ready_nx, w_ready_nx, b_valid_nx;
    logic [1:0]               b_resp_nx;
    logic [AXI_IDWIDTH-1:0]   b_id_nx;
    logic [AXI_USERWIDTH-1:0] b_user_nx;

    assign w_fire      = (w_state == W_DATA) && w_valid && w_ready;
    assign w_last_beat = (w_beat == BEAT_W'(BURST_LENGTH - 1));
    // w_last must mark exactly the final beat; any other placement is a protocol error.
    assign w_err_now   = w_err | (w_last != w_last_beat);

    always_comb begin
        w_state_nx  = w_state;
        w_line_nx   = w_line;
        w_beat_nx   = w_beat;
        w_err_nx    = w_err;
        aw_ready_nx = aw_ready;
        w_ready_nx  = w_ready;
        b_valid_nx  = b_valid;
        b_resp_nx   = b_resp;
        b_id_nx     = b_id;
        b_user_nx   = b_user;
        case (w_state)
            W_IDLE: begin
                if (aw_valid && aw_ready) begin
                    w_line_nx   = aw_addr[OFF +: LINE_W];
                    w_beat_nx   = '0;
                    w_err_nx    = 1'b0;
                    b_id_nx     = aw_id;
                    b_user_nx   = aw_user;
                    aw_ready_nx = 1'b0;
                    w_ready_nx  = 1'b1;
                    w_state_nx  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    w_err_nx  = w_err_now;
                    w_beat_nx = w_beat + BEAT_W'(1);
                    if (w_last_beat) begin
                        w_ready_nx = 1'b0;
                        b_valid_nx = 1'b1;
                        b_resp_nx  = w_err_now ? 2'b10 : 2'b00;
                        w_state_nx = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_valid && b_ready) begin
                    b_valid_nx  = 1'b0;
                    aw_ready_nx = 1'b1;
                    w_state_nx  = W_IDLE;
                end
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            w_line   <= '0;
            w_beat   <= '0;
            w_err    <= 1'b0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= 2'b00;
            b_id     <= '0;
            b_user   <= '0;
        end else begin
            w_state  <= w_state_nx;
            w_line   <= w_line_nx;
            w_beat   <= w_beat_nx;
            w_err    <= w_err_nx;
            aw_ready <= aw_ready_nx;
            w_ready  <= w_ready_nx;
            b_valid  <= b_valid_nx;
            b_resp   <= b_resp_nx;
            b_id     <= b_id_nx;
            b_user   <= b_user_nx;
        end
    end

    // Byte-strobed storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) mem[{w_line, w_beat}][i*8 +: 8] <= w_data[i*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t                  r_state, r_state_nx;
    logic [LINE_W-1:0]        r_line, r_line_nx;
    logic [BEAT_W-1:0]        r_beat, r_beat_nx;
    logic [LAT_W-1:0]         lat_cnt, lat_nx;
    logic                     ar_ready_nx, r_valid_nx, r_last_nx;
    logic [AXI_DATAWIDTH-1:0] r_data_nx;
    logic [AXI_IDWIDTH-1:0]   r_id_nx;
    logic [AXI_USERWIDTH-1:0] r_user_nx;

    always_comb begin
        r_state_nx  = r_state;
        r_line_nx   = r_line;
        r_beat_nx   = r_beat;
        lat_nx      = lat_cnt;
        ar_ready_nx = ar_ready;
        r_valid_nx  = r_valid;
        r_last_nx   = r_last;
        r_data_nx   = r_data;
        r_id_nx     = r_id;
        r_user_nx   = r_user;
        case (r_state)
            R_IDLE: begin
                if (ar_valid && ar_ready) begin
                    r_line_nx   = ar_addr[OFF +: LINE_W];
                    r_beat_nx   = '0;
                    r_id_nx     = ar_id;
                    r_user_nx   = ar_user;
                    ar_ready_nx = 1'b0;
                    lat_nx      = LAT_W'(READ_LATENCY - 1);
                    r_state_nx  = R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_cnt == '0) begin
                    r_beat_nx  = '0;
                    r_valid_nx = 1'b1;
                    r_data_nx  = mem[{r_line, r_beat_nx}];
                    r_last_nx  = (r_beat_nx == BEAT_W'(BURST_LENGTH - 1));
                    r_state_nx = R_DATA;
                end else begin
                    lat_nx = lat_cnt - LAT_W'(1);
                end
            end
            R_DATA: begin
                // Registered beat fields only change on acceptance, so they hold while stalled.
                if (r_valid && r_ready) begin
                    if (r_last) begin
                        r_valid_nx  = 1'b0;
                        r_last_nx   = 1'b0;
                        ar_ready_nx = 1'b1;
                        r_state_nx  = R_IDLE;
                    end else begin
                        r_beat_nx = r_beat + BEAT_W'(1);
                        r_data_nx = mem[{r_line, r_beat_nx}];
                        r_last_nx = (r_beat_nx == BEAT_W'(BURST_LENGTH - 1));
                    end
                end
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= R_IDLE;
            r_line   <= '0;
            r_beat   <= '0;
            lat_cnt  <= '0;
            ar_ready <= 1'b1;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
            r_id     <= '0;
            r_user   <= '0;
        end else begin
            r_state  <= r_state_nx;
            r_line   <= r_line_nx;
            r_beat   <= r_beat_nx;
            lat_cnt  <= lat_nx;
            ar_ready <= ar_ready_nx;
            r_valid  <= r_valid_nx;
            r_last   <= r_last_nx;
            r_data   <= r_data_nx;
            r_id     <= r_id_nx;
            r_user   <= r_user_nx;
        end
    end

endmodule

// File: tb/tb_axi_burst_responder.sv
// Directed bench for axi_burst_responder: write/read bursts, strobes, protocol error,
// backpressure, concurrent wrap-around access and reset mid-burst.
module tb_axi_burst_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ar_id, aw_id, r_id, b_id;
    logic        ar_user, aw_user, r_user, b_user;
    logic [31:0] ar_addr, aw_addr;
    logic        ar_valid, ar_ready, aw_valid, aw_ready;
    logic [63:0] w_data, r_data;
    logic [7:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic        r_last, r_valid, r_ready;
    logic [1:0]  r_resp, b_resp;
    logic        b_valid, b_ready;

    int checks = 0;
    int failures = 0;

    logic [63:0] wd [8];
    logic [7:0]  ws [8];
    logic [63:0] exp_q [8];

    axi_burst_responder dut (
        .clk(clk), .rst(rst),
        .ar_id(ar_id), .ar_user(ar_user), .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .aw_id(aw_id), .aw_user(aw_user), .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .r_id(r_id), .r_user(r_user), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
        .r_valid(r_valid), .r_ready(r_ready),
        .b_id(b_id), .b_user(b_user), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full 8-beat write burst from wd/ws; w_last placed on beat last_at.
    task automatic wr_burst(input logic [31:0] addr, input logic [3:0] id, input int last_at,
                            input int stall, input logic [1:0] resp);
        check("w_ready_before_aw", w_ready, 1'b0);
        check("aw_ready_idle", aw_ready, 1'b1);
        aw_addr = addr; aw_id = id; aw_user = 1'b1; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        check("aw_ready_busy", aw_ready, 1'b0);
        for (int b = 0; b < 8; b++) begin
            check("w_ready_beat", w_ready, 1'b1);
            w_valid = 1'b1; w_data = wd[b]; w_strb = ws[b]; w_last = (b == last_at);
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        check("b_valid_rise", b_valid, 1'b1);
        check("b_resp", b_resp, resp);
        check("b_id", b_id, id);
        check("b_user", b_user, 1'b1);
        check("w_ready_done", w_ready, 1'b0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("b_valid_stall", b_valid, 1'b1);
            check("b_resp_stall", b_resp, resp);
            check("aw_ready_stall", aw_ready, 1'b0);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("b_valid_clear", b_valid, 1'b0);
        check("aw_ready_back", aw_ready, 1'b1);
    endtask

    // One read burst checked against exp_q; toggle drives r_ready as 1010...
    task automatic rd_burst(input logic [31:0] addr, input logic [3:0] id, input bit toggle);
        int beat;
        int cyc;
        logic [63:0] held;
        ar_addr = addr; ar_id = id; ar_user = id[0]; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        check("ar_ready_busy", ar_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("r_valid_latency", r_valid, 1'b0);
            tick();
        end
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 64) begin
            r_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check("r_valid_beat", r_valid, 1'b1);
            check("r_data", r_data, exp_q[beat]);
            check("r_last", r_last, (beat == 7));
            check("r_id", r_id, id);
            check("r_user", r_user, id[0]);
            check("r_resp", r_resp, 2'b00);
            held = r_data;
            tick();
            cyc++;
            if (r_ready) beat++;
            else check("r_data_stall", r_data, held);
        end
        r_ready = 1'b0;
        check("r_burst_beats", 64'(beat), 64'd8);
        check("r_valid_end", r_valid, 1'b0);
        check("ar_ready_back", ar_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        ar_id = '0; ar_user = 1'b0; ar_addr = '0; ar_valid = 1'b0;
        aw_id = '0; aw_user = 1'b0; aw_addr = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        r_ready = 1'b0; b_ready = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_ar_ready", ar_ready, 1'b1);
        check("rst_aw_ready", aw_ready, 1'b1);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_r_last", r_last, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_data", r_data, 64'h0);
        check("rst_b_resp", b_resp, 2'b00);
        check("rst_ids", {b_id, r_id}, 8'h00);
        rst = 1'b0;
        tick();

        // write line 1 with data = beat index, then read it back
        for (int i = 0; i < 8; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; exp_q[i] = 64'(i); end
        wr_burst(32'h40, 4'h5, 7, 0, 2'b00);
        rd_burst(32'h40, 4'hA, 1'b0);

        // partial strobe on line 2
        for (int i = 0; i < 8; i++) begin wd[i] = 64'hFFFF_FFFF_FFFF_FFFF; ws[i] = 8'hFF; end
        wr_burst(32'h80, 4'h2, 7, 0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            wd[i] = 64'h1234; ws[i] = 8'h00; exp_q[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        wd[0] = 64'h0; ws[0] = 8'h0F; exp_q[0] = 64'hFFFF_FFFF_0000_0000;
        wr_burst(32'h80, 4'h3, 7, 0, 2'b00);
        rd_burst(32'h80, 4'h4, 1'b0);

        // early w_last on beat 3: full burst accepted, SLVERR; B stalled 5 cycles
        for (int i = 0; i < 8; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; exp_q[i] = wd[i]; end
        wr_burst(32'h140, 4'hC, 3, 5, 2'b10);
        // readback under 1010 r_ready backpressure
        rd_burst(32'h140, 4'hD, 1'b1);

        // concurrent AR to line 3 and AW to 0x400 (wraps to line 0)
        for (int i = 0; i < 8; i++) begin wd[i] = 64'h300 + 64'(i); ws[i] = 8'hFF; exp_q[i] = wd[i]; end
        wr_burst(32'hC0, 4'h1, 7, 0, 2'b00);
        for (int i = 0; i < 8; i++) wd[i] = 64'h5A00 + 64'(i);
        fork
            rd_burst(32'hC0, 4'h6, 1'b0);
            wr_burst(32'h400, 4'h9, 7, 0, 2'b00);
        join
        for (int i = 0; i < 8; i++) exp_q[i] = 64'h5A00 + 64'(i);
        rd_burst(32'h0, 4'h7, 1'b0);

        // reset while beat 4 of a read burst is presented
        ar_addr = 32'h40; ar_id = 4'h3; ar_user = 1'b1; ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
        repeat (4) tick();
        r_ready = 1'b1;
        repeat (4) tick();
        check("rstmid_beat4_data", r_data, 64'h4);
        check("rstmid_beat4_valid", r_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_r_valid", r_valid, 1'b0);
        check("rstmid_ar_ready", ar_ready, 1'b1);
        check("rstmid_r_last", r_last, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_no_beat", r_valid, 1'b0);
        end
        r_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
